// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD nibble writer.
// Contents:
//   state_t         - writer FSM states (power-up, wake-up, byte transfer, settle)
//   WAKE_NIB_*      - nibbles of the 4-bit wake-up sequence
//   CMD_*           - HD44780 command codes streamed by the clock core
//   max_of4()       - helper used to size the shared delay counter
//   is_long_cmd()   - true for commands that need the long settle time
package lcd_pkg;

  typedef enum logic [3:0] {
    ST_PWR_WAIT,
    ST_WAKE_SETUP,
    ST_WAKE_EN,
    ST_WAKE_GAP,
    ST_IDLE,
    ST_HI_SETUP,
    ST_HI_EN,
    ST_HI_GAP,
    ST_LO_SETUP,
    ST_LO_EN,
    ST_LO_GAP,
    ST_SETTLE
  } state_t;

  // Three "8-bit mode" nibbles followed by the switch to 4-bit mode.
  localparam logic [3:0] WAKE_NIB_8BIT = 4'h3;
  localparam logic [3:0] WAKE_NIB_4BIT = 4'h2;
  localparam int         WAKE_COUNT    = 4;

  localparam logic [7:0] CMD_CLEAR           = 8'h01;
  localparam logic [7:0] CMD_HOME            = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT        = 8'h03;  // DB0 is don't-care for home
  localparam logic [7:0] CMD_FUNC_4BIT_2LINE = 8'h28;
  localparam logic [7:0] CMD_DISP_ON         = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_INC       = 8'h06;
  localparam logic [7:0] CMD_LINE1           = 8'h80;
  localparam logic [7:0] CMD_LINE2           = 8'hC0;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == CMD_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_nibble_writer_if.sv
// Byte stream from the clock/alarm core into the LCD nibble writer.
//   in_valid - byte offered (master)
//   in_rs    - 0 = command, 1 = character data (master)
//   in_data  - byte to write (master)
//   in_ready - writer can accept a byte this cycle (slave)
interface lcd_nibble_writer_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;

  modport master (output in_valid, output in_rs, output in_data, input in_ready);
  modport slave  (input in_valid, input in_rs, input in_data, output in_ready);
endinterface

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter shared by every waiting state of the LCD writer.
//   clk, rst - clock, asynchronous active-high reset (count cleared to 0)
//   load     - load `value` this edge (takes priority over counting)
//   value    - duration in cycles of the state being entered (>= 1)
//   zero     - the count reaches 0 on this edge: last cycle of the wait
//   clear    - count is 0, i.e. nothing loaded since reset or wait finished
module lcd_delay_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             zero,
  output logic             clear
);

  logic [WIDTH-1:0] count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  // A load of N therefore gives exactly N cycles before `zero` ends the wait.
  assign zero  = (count_q == WIDTH'(1));
  assign clear = (count_q == '0);

endmodule

// File: rtl/lcd_nibble_writer.sv
// Streams command/data bytes onto a 4-bit HD44780 bus as high-then-low
// nibbles and runs the power-on 4-bit wake-up sequence by itself.
//   clk, rst  - 12 MHz clock, asynchronous active-high reset
//   bus       - byte stream (valid/ready, rs, data), slave side
//   init_done - wake-up sequence complete, sticky until reset
//   lcd_rs    - LCD register select
//   lcd_en    - LCD enable strobe
//   lcd_data  - LCD DB7..DB4
// All outputs are registered. The LCD pins are decoded from the current
// state one cycle late, so rs/data settle one cycle before en rises.
module lcd_nibble_writer
  import lcd_pkg::*;
#(
  parameter int EN_HIGH   = 800,
  parameter int EN_LOW    = 800,
  parameter int LONG_WAIT = 60000,
  parameter int INIT_WAIT = 12000000
) (
  input  logic                 clk,
  input  logic                 rst,
  lcd_nibble_writer_if.slave   bus,
  output logic                 init_done,
  output logic                 lcd_rs,
  output logic                 lcd_en,
  output logic [3:0]           lcd_data
);

  localparam int TIMER_W = $clog2(max_of4(EN_HIGH, EN_LOW, LONG_WAIT, INIT_WAIT)) + 1;

  state_t               state_q, state_d;
  logic [1:0]           wake_idx;
  logic [7:0]           byte_q;
  logic                 rs_q;
  logic                 long_q;
  logic                 ready_q;
  logic                 accept;
  logic                 tmr_load, tmr_zero, tmr_clear;
  logic [TIMER_W-1:0]   tmr_value;

  // Cycles spent in a state once entered. The power-up wait is loaded from
  // inside PWR_WAIT on its first cycle, so it loads one less.
  function automatic logic [TIMER_W-1:0] load_value(input state_t s);
    case (s)
      ST_PWR_WAIT:                        return TIMER_W'(INIT_WAIT - 1);
      ST_WAKE_EN, ST_HI_EN, ST_LO_EN:     return TIMER_W'(EN_HIGH);
      ST_WAKE_GAP, ST_HI_GAP, ST_LO_GAP:  return TIMER_W'(EN_LOW);
      ST_SETTLE:                          return TIMER_W'(LONG_WAIT);
      default:                            return TIMER_W'(1);
    endcase
  endfunction

  assign accept       = bus.in_valid && ready_q;
  assign bus.in_ready = ready_q;

  lcd_delay_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_value),
    .zero  (tmr_zero),
    .clear (tmr_clear)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_PWR_WAIT:   if (tmr_zero) state_d = ST_WAKE_SETUP;
      ST_WAKE_SETUP: if (tmr_zero) state_d = ST_WAKE_EN;
      ST_WAKE_EN:    if (tmr_zero) state_d = ST_WAKE_GAP;
      ST_WAKE_GAP:   if (tmr_zero) state_d = (wake_idx == 2'(WAKE_COUNT - 1)) ? ST_IDLE
                                                                               : ST_WAKE_SETUP;
      ST_IDLE:       if (accept)   state_d = ST_HI_SETUP;
      ST_HI_SETUP:   if (tmr_zero) state_d = ST_HI_EN;
      ST_HI_EN:      if (tmr_zero) state_d = ST_HI_GAP;
      ST_HI_GAP:     if (tmr_zero) state_d = ST_LO_SETUP;
      ST_LO_SETUP:   if (tmr_zero) state_d = ST_LO_EN;
      ST_LO_EN:      if (tmr_zero) state_d = ST_LO_GAP;
      ST_LO_GAP:     if (tmr_zero) state_d = long_q ? ST_SETTLE : ST_IDLE;
      ST_SETTLE:     if (tmr_zero) state_d = ST_IDLE;
      default:                     state_d = ST_PWR_WAIT;
    endcase

    // Reset leaves the counter at 0 in PWR_WAIT; that first cycle arms it.
    tmr_load  = (state_d != state_q) || (state_q == ST_PWR_WAIT && tmr_clear);
    tmr_value = load_value(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_PWR_WAIT;
      wake_idx  <= '0;
      byte_q    <= '0;
      rs_q      <= 1'b0;
      long_q    <= 1'b0;
      ready_q   <= 1'b0;
      init_done <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_en    <= 1'b0;
      lcd_data  <= 4'h0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE);

      if (state_q == ST_IDLE && accept) begin
        byte_q <= bus.in_data;
        rs_q   <= bus.in_rs;
        long_q <= is_long_cmd(bus.in_rs, bus.in_data);
      end

      if (state_q == ST_WAKE_GAP && tmr_zero) begin
        wake_idx <= wake_idx + 2'd1;
        if (wake_idx == 2'(WAKE_COUNT - 1)) init_done <= 1'b1;
      end

      // rs/data change only while decoding a nibble's states and hold
      // otherwise, so the bus stays stable from setup until the next setup.
      case (state_q)
        ST_WAKE_SETUP, ST_WAKE_EN, ST_WAKE_GAP: begin
          lcd_rs   <= 1'b0;
          lcd_data <= (wake_idx == 2'(WAKE_COUNT - 1)) ? WAKE_NIB_4BIT : WAKE_NIB_8BIT;
        end
        ST_HI_SETUP, ST_HI_EN, ST_HI_GAP: begin
          lcd_rs   <= rs_q;
          lcd_data <= byte_q[7:4];
        end
        ST_LO_SETUP, ST_LO_EN, ST_LO_GAP: begin
          lcd_rs   <= rs_q;
          lcd_data <= byte_q[3:0];
        end
        default: ;
      endcase

      lcd_en <= (state_q == ST_WAKE_EN) || (state_q == ST_HI_EN) || (state_q == ST_LO_EN);
    end
  end

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Directed self-checking bench for lcd_nibble_writer with short timings
// (EN_HIGH=4, EN_LOW=3, LONG_WAIT=20, INIT_WAIT=10). A bus monitor records
// every lcd_en pulse (rs, nibble, rise cycle, width); the stimulus compares
// those records and handshake timing against hand-computed values.
module tb_lcd_nibble_writer;
  localparam int EN_HIGH   = 4;
  localparam int EN_LOW    = 3;
  localparam int LONG_WAIT = 20;
  localparam int INIT_WAIT = 10;
  localparam int BYTE_CYC  = 2 * (1 + EN_HIGH + EN_LOW);          // 16
  localparam int INIT_CYC  = INIT_WAIT + 4 * (1 + EN_HIGH + EN_LOW); // 42

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init_done, lcd_rs, lcd_en;
  logic [3:0] lcd_data;

  lcd_nibble_writer_if bus ();

  lcd_nibble_writer #(
    .EN_HIGH   (EN_HIGH),
    .EN_LOW    (EN_LOW),
    .LONG_WAIT (LONG_WAIT),
    .INIT_WAIT (INIT_WAIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .init_done (init_done),
    .lcd_rs    (lcd_rs),
    .lcd_en    (lcd_en),
    .lcd_data  (lcd_data)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; stable when read on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       rs;
    logic [3:0] data;
    int         rise;
    int         width;
  } pulse_t;

  pulse_t pulses[$];
  pulse_t cur;
  logic   en_prev  = 1'b0;
  int     hold_err = 0;

  always @(negedge clk) begin
    if (lcd_en && !en_prev) begin
      cur.rs    = lcd_rs;
      cur.data  = lcd_data;
      cur.rise  = cyc;
      cur.width = 1;
    end else if (lcd_en) begin
      cur.width = cur.width + 1;
      if (lcd_data !== cur.data || lcd_rs !== cur.rs) hold_err = hold_err + 1;
    end else if (en_prev) begin
      pulses.push_back(cur);
    end
    en_prev = lcd_en;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare the recorded pulses against an expected nibble list.
  task automatic check_pulses(input string tag, input logic [3:0] exp_nib[],
                              input logic exp_rs, input int first_rise);
    check({tag, "_count"}, 32'(pulses.size()), 32'(exp_nib.size()));
    for (int i = 0; i < exp_nib.size() && i < pulses.size(); i++) begin
      check($sformatf("%s_nib%0d", tag, i), 32'(pulses[i].data), 32'(exp_nib[i]));
      check($sformatf("%s_rs%0d", tag, i), 32'(pulses[i].rs), 32'(exp_rs));
      check($sformatf("%s_width%0d", tag, i), 32'(pulses[i].width), 32'(EN_HIGH));
    end
    if (pulses.size() > 0) check({tag, "_first_rise"}, 32'(pulses[0].rise), 32'(first_rise));
  endtask

  // Called on the falling edge where rst was released (cyc == rel).
  task automatic wait_init(input string tag, input int rel);
    logic [3:0] wake[] = '{4'h3, 4'h3, 4'h3, 4'h2};
    int seen = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (init_done) begin
        seen = cyc - rel;
        break;
      end
    end
    check({tag, "_init_cycle"}, 32'(seen), 32'(INIT_CYC));
    check({tag, "_ready_at_init"}, 32'(bus.in_ready), 32'd1);
    check_pulses({tag, "_wake"}, wake, 1'b0, rel + INIT_WAIT + 2);
    for (int i = 0; i < 4 && i < pulses.size(); i++)
      check($sformatf("%s_wake_rise%0d", tag, i), 32'(pulses[i].rise),
            32'(rel + INIT_WAIT + 2 + 8 * i));
  endtask

  // Offer a byte from a falling edge; returns the accept edge index.
  task automatic send_byte(input logic rs, input logic [7:0] data, output int n);
    n = -1;
    bus.in_valid = 1'b1;
    bus.in_rs    = rs;
    bus.in_data  = data;
    for (int i = 0; i < 200; i++) begin
      if (bus.in_ready) begin
        @(negedge clk);
        n = cyc;
        break;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (n < 0) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_ready(input string tag, input int n, input int exp_cyc);
    int seen = -1;
    for (int i = 0; i < 200; i++) begin
      if (bus.in_ready) begin
        seen = cyc - n;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(seen), 32'(exp_cyc));
  endtask

  task automatic run_byte(input string tag, input logic rs, input logic [7:0] data,
                          input int exp_cyc);
    int n;
    logic [3:0] nibs[];
    nibs = new[2];
    nibs[0] = data[7:4];
    nibs[1] = data[3:0];
    pulses.delete();
    send_byte(rs, data, n);
    check({tag, "_ready_low"}, 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check({tag, "_hi_at_n1"}, 32'(lcd_data), 32'(data[7:4]));
    wait_ready(tag, n, exp_cyc);
    @(negedge clk);
    check_pulses(tag, nibs, rs, n + 2);
  endtask

  initial begin
    logic [7:0] stream[3] = '{8'h28, 8'h0C, 8'h06};
    logic [3:0] stream_nib[] = '{4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h6};
    logic [3:0] pair_41[] = '{4'h4, 4'h1};
    int acc[3];
    int n, rel;

    bus.in_valid = 1'b0;
    bus.in_rs    = 1'b0;
    bus.in_data  = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_lcd_rs", 32'(lcd_rs), 32'd0);
    check("rst_lcd_en", 32'(lcd_en), 32'd0);
    check("rst_lcd_data", 32'(lcd_data), 32'd0);

    rst = 1'b0;
    rel = cyc;
    wait_init("pwr", rel);

    run_byte("data31", 1'b1, 8'h31, BYTE_CYC);
    run_byte("clear", 1'b0, 8'h01, BYTE_CYC + LONG_WAIT);
    run_byte("data01", 1'b1, 8'h01, BYTE_CYC);
    run_byte("home", 1'b0, 8'h02, BYTE_CYC + LONG_WAIT);

    // Valid held high across three commands: one accept per IDLE entry.
    pulses.delete();
    bus.in_valid = 1'b1;
    bus.in_rs    = 1'b0;
    foreach (acc[i]) acc[i] = -100;
    for (int b = 0; b < 3; b++) begin
      bus.in_data = stream[b];
      for (int i = 0; i < 200; i++) begin
        if (bus.in_ready) break;
        @(negedge clk);
      end
      @(negedge clk);
      acc[b] = cyc;
    end
    bus.in_valid = 1'b0;
    check("stream_gap01", 32'(acc[1] - acc[0]), 32'(BYTE_CYC + 1));
    check("stream_gap12", 32'(acc[2] - acc[1]), 32'(BYTE_CYC + 1));
    wait_ready("stream", acc[2], BYTE_CYC);
    repeat (30) @(negedge clk);
    check_pulses("stream", stream_nib, 1'b0, acc[0] + 2);

    // A byte offered while busy (during HI_EN) is ignored.
    pulses.delete();
    send_byte(1'b1, 8'h41, n);
    @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_ready("busy_offer", n, BYTE_CYC);
    repeat (40) @(negedge clk);
    check("busy_offer_ready", 32'(bus.in_ready), 32'd1);
    check_pulses("busy_offer", pair_41, 1'b1, n + 2);

    // Reset in the middle of the low nibble strobe aborts the byte.
    pulses.delete();
    send_byte(1'b1, 8'h52, n);
    repeat (11) @(negedge clk);
    check("abort_en_before", 32'(lcd_en), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_en", 32'(lcd_en), 32'd0);
    check("abort_init_done", 32'(init_done), 32'd0);
    check("abort_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) @(negedge clk);
    pulses.delete();
    rst = 1'b0;
    rel = cyc;
    wait_init("rerun", rel);
    repeat (40) @(negedge clk);
    check("rerun_no_resume", 32'(pulses.size()), 32'd4);
    check("rerun_ready", 32'(bus.in_ready), 32'd1);

    check("bus_hold_during_en", 32'(hold_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
